// File: rtl/uart_txsm_gen_if.sv
// Transmit-FIFO read handshake between the UART TX state machine and its FIFO.
interface uart_txsm_gen_if;
    logic       TF_EF;
    logic [7:0] THR;
    logic       TF_RE;

    modport master (input TF_EF, input THR, output TF_RE);
    modport slave  (output TF_EF, output THR, input TF_RE);
endinterface

// File: rtl/uart_txsm_gen.sv
// 16x-oversampled UART transmit state machine with internal baud-tick generator.
// Optional break generator enabled by defining UART_TXSM_BREAK_EN.
module uart_txsm_gen #(
    parameter int unsigned pDivW = 8
) (
    input  logic             Clk,
    input  logic             nRst,
    input  logic [pDivW-1:0] BaudDiv,
    input  logic [1:0]       Len,
    input  logic             NumStop,
    input  logic             ParEn,
    input  logic [1:0]       Par,
    uart_txsm_gen_if.master  fifo,
    input  logic             CTSi,
    input  logic             Break,
    output logic             TxD,
    output logic             DE,
    output logic             CE_16x,
    output logic             TxIdle,
    output logic             TxStart,
    output logic             TxShift,
    output logic             TxStop
);

    // Encoding bits [5:2] are the registered decodes {stop, shift, start, idle}.
    typedef enum logic [5:0] {
        ST_IDLE  = 6'b000100,
        ST_START = 6'b001000,
        ST_SBIT  = 6'b001001,
        ST_DATA  = 6'b010000,
        ST_PAR   = 6'b010001,
`ifdef UART_TXSM_BREAK_EN
        ST_BRK   = 6'b000010,
`endif
        ST_STOP  = 6'b100000
    } state_t;

    state_t           state;
    logic [pDivW-1:0] cnt;
    logic [3:0]       tick;
    logic [2:0]       bit_cnt;
    logic [7:0]       sr;
    logic             par_bit;
    logic             stop_two;
    logic [7:0]       data_m;

    function automatic logic [7:0] mask_of(input logic [1:0] len, input logic [7:0] d);
        return d & (8'hFF >> (2'd3 - len));
    endfunction

    function automatic logic par_of(input logic [1:0] mode, input logic [7:0] d);
        case (mode)
            2'd0:    return ~^d;
            2'd1:    return ^d;
            2'd2:    return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign data_m  = mask_of(Len, fifo.THR);
    assign TxIdle  = state[2];
    assign TxStart = state[3];
    assign TxShift = state[4];
    assign TxStop  = state[5];

`ifndef UART_TXSM_BREAK_EN
    logic unused_break;
    assign unused_break = Break;
`endif

    always_ff @(posedge Clk) begin
        if (!nRst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            CE_16x     <= 1'b0;
            tick       <= '0;
            bit_cnt    <= '0;
            sr         <= '0;
            par_bit    <= 1'b0;
            stop_two   <= 1'b0;
            TxD        <= 1'b1;
            DE         <= 1'b0;
            fifo.TF_RE <= 1'b0;
        end else begin
            fifo.TF_RE <= 1'b0;

            // Baud tick: reload on zero, BaudDiv sampled only here.
            if (cnt == '0) begin
                CE_16x <= 1'b1;
                cnt    <= BaudDiv;
            end else begin
                CE_16x <= 1'b0;
                cnt    <= cnt - pDivW'(1);
            end

            case (state)
                ST_IDLE: begin
                    TxD <= 1'b1;
                    DE  <= 1'b0;
`ifdef UART_TXSM_BREAK_EN
                    if (Break) begin
                        state <= ST_BRK;
                        TxD   <= 1'b0;
                        DE    <= 1'b1;
                        tick  <= '0;
                    end else
`endif
                    if (!fifo.TF_EF) begin
                        fifo.TF_RE <= 1'b1;
                        sr         <= data_m;
                        par_bit    <= par_of(Par, data_m);
                        state      <= ST_START;
                    end
                end

                ST_START: begin
                    if (CE_16x && CTSi) begin
                        state <= ST_SBIT;
                        TxD   <= 1'b0;
                        DE    <= 1'b1;
                        tick  <= '0;
                    end
                end

                default: begin
                    if (CE_16x) begin
                        tick <= tick + 4'd1;
                        if (tick == 4'd15) begin
                            case (state)
                                ST_SBIT: begin
                                    state   <= ST_DATA;
                                    TxD     <= sr[0];
                                    sr      <= sr >> 1;
                                    bit_cnt <= '0;
                                end
                                ST_DATA: begin
                                    if (bit_cnt == 3'(Len) + 3'd4) begin
                                        if (ParEn) begin
                                            state <= ST_PAR;
                                            TxD   <= par_bit;
                                        end else begin
                                            state    <= ST_STOP;
                                            TxD      <= 1'b1;
                                            stop_two <= NumStop;
                                        end
                                    end else begin
                                        TxD     <= sr[0];
                                        sr      <= sr >> 1;
                                        bit_cnt <= bit_cnt + 3'd1;
                                    end
                                end
                                ST_PAR: begin
                                    state    <= ST_STOP;
                                    TxD      <= 1'b1;
                                    stop_two <= NumStop;
                                end
                                ST_STOP: begin
                                    if (stop_two) begin
                                        stop_two <= 1'b0;
                                    end else if (!fifo.TF_EF) begin
                                        // Back-to-back: this tick doubles as the CTS-qualified start tick.
                                        fifo.TF_RE <= 1'b1;
                                        sr         <= data_m;
                                        par_bit    <= par_of(Par, data_m);
                                        if (CTSi) begin
                                            state <= ST_SBIT;
                                            TxD   <= 1'b0;
                                        end else begin
                                            state <= ST_START;
                                            DE    <= 1'b0;
                                        end
                                    end else begin
                                        state <= ST_IDLE;
                                        DE    <= 1'b0;
                                    end
                                end
`ifdef UART_TXSM_BREAK_EN
                                ST_BRK: begin
                                    if (!Break) begin
                                        state    <= ST_STOP;
                                        TxD      <= 1'b1;
                                        stop_two <= 1'b0;
                                    end
                                end
`endif
                                default: begin
                                    state <= ST_IDLE;
                                    TxD   <= 1'b1;
                                    DE    <= 1'b0;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_txsm_gen.sv
// Scoreboard bench for uart_txsm_gen: expected serial frames are queued by the stimulus
// and compared by an independent line monitor sampling TxD at bit midpoints.
module tb_uart_txsm_gen;
    localparam int unsigned DIV_W = 8;

    typedef struct {
        int          n;
        logic [15:0] bits;
    } frame_t;

    logic             Clk = 1'b0;
    logic             nRst;
    logic [DIV_W-1:0] BaudDiv;
    logic [1:0]       Len;
    logic             NumStop;
    logic             ParEn;
    logic [1:0]       Par;
    logic             CTSi;
    logic             Break;
    logic             TxD, DE, CE_16x, TxIdle, TxStart, TxShift, TxStop;

    int n_cmp = 0;
    int n_err = 0;
    int bit_clks = 64;
    logic brk_mode = 1'b0;

    frame_t     exp_q[$];
    logic [7:0] words [16];
    logic [3:0] wr_ptr = 4'd0;
    logic [3:0] rd_ptr = 4'd0;

    int cyc = 0;
    int re_cnt = 0;
    int re_time [32];
    int de_cnt = 0;
    int de_fall = 0;

    always #5 Clk = ~Clk;

    uart_txsm_gen_if ifc ();

    assign ifc.TF_EF = (rd_ptr == wr_ptr);
    assign ifc.THR   = words[rd_ptr];

    uart_txsm_gen #(.pDivW(DIV_W)) dut (
        .Clk     (Clk),
        .nRst    (nRst),
        .BaudDiv (BaudDiv),
        .Len     (Len),
        .NumStop (NumStop),
        .ParEn   (ParEn),
        .Par     (Par),
        .fifo    (ifc),
        .CTSi    (CTSi),
        .Break   (Break),
        .TxD     (TxD),
        .DE      (DE),
        .CE_16x  (CE_16x),
        .TxIdle  (TxIdle),
        .TxStart (TxStart),
        .TxShift (TxShift),
        .TxStop  (TxStop)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [7:0] w, input int n, input logic [15:0] bits);
        frame_t f;
        f.n    = n;
        f.bits = bits;
        exp_q.push_back(f);
        words[wr_ptr] = w;
        wr_ptr        = wr_ptr + 4'd1;
    endtask

    task automatic wait_done(input int limit);
        int k;
        for (k = 0; k < limit; k++) begin
            @(negedge Clk);
            if (exp_q.size() == 0 && TxIdle && rd_ptr == wr_ptr) break;
        end
        if (k == limit) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_done: timeout after %0d cycles", limit);
        end
    endtask

    // FIFO pop model and TF_RE / DE activity tracker
    initial begin
        logic re_prev, de_prev;
        re_prev = 1'b0;
        de_prev = 1'b0;
        forever begin
            @(negedge Clk);
            cyc++;
            if (ifc.TF_RE) begin
                chk("tf_re_not_back_to_back", 32'(re_prev), 32'd0);
                if (re_cnt < 32) re_time[re_cnt] = cyc;
                re_cnt++;
                rd_ptr = rd_ptr + 4'd1;
            end
            re_prev = ifc.TF_RE;
            if (DE) de_cnt++;
            if (de_prev && !DE) de_fall++;
            de_prev = DE;
        end
    end

    // Line monitor: captures each frame at bit midpoints and checks it against the queue
    initial begin
        int n, b, w;
        logic [15:0] got;
        logic aborted, prev;
        frame_t f;
        prev = 1'b1;
        forever begin
            @(negedge Clk);
            if (nRst && !brk_mode && prev && !TxD) begin
                n = (exp_q.size() > 0) ? exp_q[0].n : 10;
                got = '0;
                aborted = 1'b0;
                b = 0;
                while (b < n && !aborted) begin
                    w = (b == 0) ? bit_clks / 2 : bit_clks;
                    for (int k = 0; k < w && !aborted; k++) begin
                        @(negedge Clk);
                        if (!nRst) aborted = 1'b1;
                    end
                    got[b] = TxD;
                    b++;
                end
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    f = exp_q.pop_front();
                    if (!aborted) chk("frame_bits", 32'(got), 32'(f.bits));
                end
            end
            prev = nRst ? TxD : 1'b1;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int re0, de0, fall0, ce_seen, low, k;

        nRst = 1'b0; BaudDiv = 8'd3; Len = 2'd3; NumStop = 1'b0; ParEn = 1'b0;
        Par = 2'd0; CTSi = 1'b1; Break = 1'b0;
        bit_clks = 64;
        repeat (3) @(negedge Clk);

        chk("rst_txd",    32'(TxD),     32'd1);
        chk("rst_de",     32'(DE),      32'd0);
        chk("rst_idle",   32'(TxIdle),  32'd1);
        chk("rst_start",  32'(TxStart), 32'd0);
        chk("rst_shift",  32'(TxShift), 32'd0);
        chk("rst_stop",   32'(TxStop),  32'd0);
        chk("rst_tf_re",  32'(ifc.TF_RE), 32'd0);
        chk("rst_ce16x",  32'(CE_16x),  32'd0);

        // Divider 3: tick on the first edge after release, then every 4 clocks
        nRst = 1'b1;
        ce_seen = 0;
        repeat (8) begin
            @(negedge Clk);
            if (CE_16x) ce_seen++;
        end
        chk("ce16x_div3_count", 32'(ce_seen), 32'd2);

        // 8N1, divider 0, 0x55
        BaudDiv = 8'd0; bit_clks = 16;
        repeat (8) @(negedge Clk);
        re0 = re_cnt; de0 = de_cnt;
        send(8'h55, 10, 16'h02AA);
        wait_done(3000);
        chk("8n1_pops",    32'(re_cnt - re0), 32'd1);
        chk("8n1_de_clks", 32'(de_cnt - de0), 32'd160);
        chk("8n1_idle",    32'(TxIdle), 32'd1);

        // 7E2, divider 3, 0xC1 (bit 7 dropped, parity 0)
        BaudDiv = 8'd3; bit_clks = 64; Len = 2'd2; ParEn = 1'b1; Par = 2'd1; NumStop = 1'b1;
        repeat (8) @(negedge Clk);
        re0 = re_cnt; de0 = de_cnt;
        send(8'hC1, 11, 16'h0682);
        wait_done(3000);
        chk("7e2_pops",    32'(re_cnt - re0), 32'd1);
        chk("7e2_de_clks", 32'(de_cnt - de0), 32'd704);

        // 5 bits odd parity, 0x1F -> parity 0
        BaudDiv = 8'd0; bit_clks = 16; Len = 2'd0; ParEn = 1'b1; Par = 2'd0; NumStop = 1'b0;
        repeat (8) @(negedge Clk);
        de0 = de_cnt;
        send(8'h1F, 8, 16'h00BE);
        wait_done(3000);
        chk("5o1_de_clks", 32'(de_cnt - de0), 32'd128);

        // CTS held low: one pop, parked in Start with line idle and driver off
        Len = 2'd3; ParEn = 1'b0;
        CTSi = 1'b0;
        re0 = re_cnt;
        send(8'h3C, 10, 16'h0278);
        repeat (40) @(negedge Clk);
        chk("cts_pops",  32'(re_cnt - re0), 32'd1);
        chk("cts_txd",   32'(TxD),     32'd1);
        chk("cts_de",    32'(DE),      32'd0);
        chk("cts_start", 32'(TxStart), 32'd1);
        CTSi = 1'b1;
        @(negedge Clk);
        chk("cts_go_txd", 32'(TxD), 32'd0);
        chk("cts_go_de",  32'(DE),  32'd1);
        wait_done(3000);

        // Three words back to back
        repeat (4) @(negedge Clk);
        re0 = re_cnt; de0 = de_cnt; fall0 = de_fall;
        send(8'hA3, 10, 16'h0346);
        send(8'h0F, 10, 16'h021E);
        send(8'hFF, 10, 16'h03FE);
        wait_done(6000);
        chk("b2b_pops",     32'(re_cnt - re0), 32'd3);
        chk("b2b_re_space", 32'(re_time[re0 + 2] - re_time[re0 + 1]), 32'd160);
        chk("b2b_de_clks",  32'(de_cnt - de0), 32'd480);
        chk("b2b_de_falls", 32'(de_fall - fall0), 32'd1);

        // Reset during data bit 3, then three more words
        repeat (4) @(negedge Clk);
        send(8'h00, 10, 16'h0200);
        for (k = 0; k < 200; k++) begin
            @(negedge Clk);
            if (!TxD) break;
        end
        chk("rst_mid_started", 32'(TxD), 32'd0);
        repeat (72) @(negedge Clk);
        chk("rst_mid_in_data", 32'(TxShift), 32'd1);
        nRst = 1'b0;
        re0 = re_cnt;
        send(8'h81, 10, 16'h0302);
        send(8'h7E, 10, 16'h02FC);
        send(8'h5A, 10, 16'h02B4);
        @(negedge Clk);
        chk("rst_mid_txd",  32'(TxD),    32'd1);
        chk("rst_mid_de",   32'(DE),     32'd0);
        chk("rst_mid_idle", 32'(TxIdle), 32'd1);
        repeat (2) @(negedge Clk);
        nRst = 1'b1;
        wait_done(6000);
        chk("rst_mid_pops", 32'(re_cnt - re0), 32'd3);

`ifdef UART_TXSM_BREAK_EN
        // Break for 40 ticks: low until the third bit boundary, then one stop bit
        repeat (4) @(negedge Clk);
        brk_mode = 1'b1;
        low = 0; de0 = de_cnt; re0 = re_cnt;
        Break = 1'b1;
        repeat (40) begin
            @(negedge Clk);
            if (!TxD) low++;
        end
        Break = 1'b0;
        for (k = 0; k < 500; k++) begin
            @(negedge Clk);
            if (TxIdle) break;
            if (!TxD) low++;
        end
        chk("brk_low_clks", 32'(low), 32'd48);
        chk("brk_de_clks",  32'(de_cnt - de0), 32'd64);
        chk("brk_pops",     32'(re_cnt - re0), 32'd0);
        chk("brk_idle",     32'(TxIdle), 32'd1);
        brk_mode = 1'b0;
`else
        // Break is ignored without the break generator
        repeat (4) @(negedge Clk);
        re0 = re_cnt; low = 0;
        Break = 1'b1;
        repeat (20) begin
            @(negedge Clk);
            if (!TxD) low++;
        end
        Break = 1'b0;
        chk("brk_ignored_low",  32'(low), 32'd0);
        chk("brk_ignored_idle", 32'(TxIdle), 32'd1);
        chk("brk_ignored_pops", 32'(re_cnt - re0), 32'd0);
`endif

        repeat (4) @(negedge Clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
